// File: rtl/wb_commit_unit_pkg.sv
// Shared types and constants for the writeback commit unit.
// Covers the default datapath width, the register index width and the multi-cycle commit entry.
package wb_commit_unit_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned REG_W     = 5;

    localparam logic RES_ALU = 1'b0;
    localparam logic RES_MEM = 1'b1;

    typedef struct packed {
        logic [REG_W-1:0]     rd;
        logic                 is_float;
        logic [WIDTH_DEF-1:0] data;
    } mc_entry_t;

endpackage

// File: rtl/wb_commit_fifo.sv
// Small synchronous FIFO that holds late multi-cycle results until a write port frees up.
// Pop is gated by the parent. The head is read from registered storage, so an entry cannot leave in the cycle it is pushed.
module wb_commit_fifo
    import wb_commit_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = mc_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  entry_t                     push_entry,
    input  logic                       pop,
    output entry_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    entry_t           mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The storage has no reset: the pointers and the count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/wb_commit_unit.sv
// Writeback commit unit: selects the pipeline result and drives the registered integer and float RF write ports.
// Multi-cycle results are merged through a FIFO that drains into a port the pipeline leaves idle.
module wb_commit_unit
    import wb_commit_unit_pkg::*;
#(
    parameter int unsigned WIDTH    = WIDTH_DEF,
    parameter int unsigned MC_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        RegWriteW,
    input  logic                        ResultSrcW,
    input  logic                        WD3SrcW,
    input  logic                        floatingWriteW,
    input  logic [WIDTH-1:0]            ALUResultW,
    input  logic [WIDTH-1:0]            ReadDataW,
    input  logic [WIDTH-1:0]            PCPlus4W,
    input  logic [4:0]                  RdW,
    input  logic                        mc_valid,
    output logic                        mc_ready,
    input  logic [4:0]                  mc_rd,
    input  logic                        mc_float,
    input  logic [WIDTH-1:0]            mc_data,
    output logic                        int_we,
    output logic [4:0]                  int_waddr,
    output logic [WIDTH-1:0]            int_wdata,
    output logic                        fp_we,
    output logic [4:0]                  fp_waddr,
    output logic [WIDTH-1:0]            fp_wdata,
    output logic                        mc_pending,
    output logic [$clog2(MC_DEPTH):0]   mc_count
);

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             is_float;
        logic [WIDTH-1:0] data;
    } commit_entry_t;

    commit_entry_t    push_entry;
    commit_entry_t    head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [WIDTH-1:0] pipe_result;
    logic             pipe_int;
    logic             pipe_fp;
    logic             drain_int;
    logic             drain_fp;

    assign push_entry = '{rd: mc_rd, is_float: mc_float, data: mc_data};

    wb_commit_fifo #(
        .DEPTH   (MC_DEPTH),
        .entry_t (commit_entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (mc_valid && mc_ready),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .count      (mc_count),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign mc_ready   = !fifo_full;
    assign mc_pending = !fifo_empty;

    always_comb begin
        pipe_result = ALUResultW;
        if (WD3SrcW)
            pipe_result = PCPlus4W;
        else if (ResultSrcW == RES_MEM)
            pipe_result = ReadDataW;
    end

    // The pipeline claims a port only on an effective write; an x0 write leaves the integer port free.
    always_comb begin
        pipe_int  = RegWriteW && !floatingWriteW && (RdW != '0);
        pipe_fp   = RegWriteW && floatingWriteW;
        pop       = !fifo_empty && (head.is_float ? !pipe_fp : !pipe_int);
        drain_int = pop && !head.is_float && (head.rd != '0);
        drain_fp  = pop && head.is_float;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_we    <= 1'b0;
            int_waddr <= '0;
            int_wdata <= '0;
            fp_we     <= 1'b0;
            fp_waddr  <= '0;
            fp_wdata  <= '0;
        end else begin
            int_we <= pipe_int || drain_int;
            if (pipe_int) begin
                int_waddr <= RdW;
                int_wdata <= pipe_result;
            end else if (drain_int) begin
                int_waddr <= head.rd;
                int_wdata <= head.data;
            end

            fp_we <= pipe_fp || drain_fp;
            if (pipe_fp) begin
                fp_waddr <= RdW;
                fp_wdata <= pipe_result;
            end else if (drain_fp) begin
                fp_waddr <= head.rd;
                fp_wdata <= head.data;
            end
        end
    end

endmodule

// File: doc/wb_commit_unit.md
Name: wb_commit_unit

Overview:
- Writeback-end consumer of the MEM/WB pipeline register outputs (ALUResultW, ReadDataW, PCPlus4W, RdW, RegWriteW, ResultSrcW, WD3SrcW, floatingWriteW).
- Selects the pipeline result and drives registered write ports for the integer and float register files.
- Merges late results from multi-cycle units (FP divide/sqrt, int divide) through a small commit FIFO that drains into whichever write port the pipeline leaves idle.

Parameters:
WIDTH, 32, datapath width
MC_DEPTH, 2, commit FIFO entries for multi-cycle results (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
RegWriteW  in  1  pipeline write enable
ResultSrcW  in  1  0=ALUResultW, 1=ReadDataW
WD3SrcW  in  1  1=PCPlus4W (link write), overrides ResultSrcW
floatingWriteW  in  1  1=target float RF, 0=integer RF
ALUResultW  in  WIDTH  ALU result
ReadDataW  in  WIDTH  load data
PCPlus4W  in  WIDTH  link address
RdW  in  5  destination register
mc_valid  in  1  multi-cycle result offered
mc_ready  out  1  FIFO can accept (count < MC_DEPTH)
mc_rd  in  5  multi-cycle destination
mc_float  in  1  multi-cycle target is float RF
mc_data  in  WIDTH  multi-cycle result
int_we  out  1  integer RF write enable (registered)
int_waddr  out  5  integer RF write address
int_wdata  out  WIDTH  integer RF write data
fp_we  out  1  float RF write enable (registered)
fp_waddr  out  5  float RF write address
fp_wdata  out  WIDTH  float RF write data
mc_pending  out  1  FIFO non-empty
mc_count  out  $clog2(MC_DEPTH)+1  FIFO occupancy

Behaviour:
- Interface: one clock clk; reset rst is asynchronous and active-high.
- Reset: all write-port outputs, FIFO pointers and count go to 0. mc_ready=1 and mc_pending=0 once reset is released. Reset mid-operation discards FIFO contents without writing them.
- Pipeline result mux: WD3SrcW ? PCPlus4W : (ResultSrcW ? ReadDataW : ALUResultW).
- Pipeline write is effective when RegWriteW=1, except an integer write with RdW=0, which is suppressed (x0 hardwired). Float f0 is writable.
- Latency: W-stage inputs sampled at edge N appear on the target port after edge N, i.e. one registered cycle.
- Port arbitration, per cycle:
  - Pipeline has absolute priority on its target port.
  - The FIFO head drains only if its target port (mc_float) is not claimed by the pipeline this cycle.
  - An integer pipeline write and a float head drain (or vice versa) commit in the same cycle.
- Head with integer target and mc_rd=0: popped with no write (int_we stays 0), consuming one arbitration slot.
- When a port has no writer, its we=0; its waddr/wdata hold their last values.
- FIFO:
  - Push on mc_valid && mc_ready.
  - mc_ready depends only on registered count (no combinational path from mc_valid or pipeline inputs).
  - A pushed entry is never drained in its push cycle; earliest drain is the next cycle.
  - Push and pop in the same cycle leave count unchanged; pointers wrap modulo MC_DEPTH.
  - Full: mc_ready=0; the upstream unit holds mc_valid/mc_rd/mc_float/mc_data stable.
  - Empty: no drain, regardless of port availability.
- Ordering: FIFO entries commit in push order. WAW between in-flight multi-cycle results and pipeline writes is prevented by the hazard unit (scoreboard on mc_rd); this block does not reorder or check it.
- Starvation: sustained same-port pipeline writes may block the head indefinitely. This is acceptable because the hazard unit stalls consumers of pending registers.

Decomposition:
- Shared package: WIDTH default, register-index width (5), result-select encoding constants (RES_ALU, RES_MEM), and a struct for a multi-cycle commit entry {rd, is_float, data}.
- One sub-module, wb_commit_fifo: parameterised synchronous FIFO with async active-high reset, pop gated externally. The top holds only the mux, the arbitration and the output registers.

Test Plan:
- Reset with RegWriteW=1 asserted -> all we/waddr/wdata = 0 during reset; first write appears one cycle after release.
- Pipeline int write, RdW=5, ALUResultW=0x11, ResultSrcW=0 -> next cycle int_we=1, int_waddr=5, int_wdata=0x11. Repeat with WD3SrcW=1, PCPlus4W=0x104 -> int_wdata=0x104. RdW=0 -> int_we=0.
- Push mc {rd=3, float=1, data=0x3F800000} while pipeline writes int x7 every cycle -> fp_we=1, fp_waddr=3 in the cycle after push, concurrent with int_we=1.
- Push mc {rd=9, int} while pipeline writes int every cycle for 4 cycles -> entry held, mc_pending=1; after RegWriteW drops, int_waddr=9 on the following cycle.
- Fill FIFO (MC_DEPTH=2) while blocked -> mc_ready=0, third offer not accepted. After unblock, entries commit in push order, one per cycle, and mc_ready returns to 1.
- Assert rst while FIFO holds 2 entries -> mc_count=0, no write of either entry ever appears.
